// File: rtl/regfile_arbiter_if.sv
// Requester/response and register-file bus for the two-requester register-file arbiter.
// The slave modport is the arbiter's view; master is the requester/register-file side.
interface regfile_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              r0_valid;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr1;
    logic [ADDR_W-1:0] r0_addr2;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_ready;

    logic              r1_valid;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr1;
    logic [ADDR_W-1:0] r1_addr2;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_ready;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp_data1;
    logic [DATA_W-1:0] rsp_data2;

    logic [ADDR_W-1:0] rf_read1;
    logic [ADDR_W-1:0] rf_read2;
    logic [ADDR_W-1:0] rf_write;
    logic [DATA_W-1:0] rf_data;
    logic              rf_readEnable;
    logic              rf_writeEnable;
    logic [DATA_W-1:0] rf_readout1;
    logic [DATA_W-1:0] rf_readout2;

    logic              busy;

    modport slave (
        input  r0_valid, r0_we, r0_addr1, r0_addr2, r0_wdata,
        input  r1_valid, r1_we, r1_addr1, r1_addr2, r1_wdata,
        output r0_ready, r1_ready,
        output rsp0_valid, rsp1_valid, rsp_data1, rsp_data2,
        output rf_read1, rf_read2, rf_write, rf_data, rf_readEnable, rf_writeEnable,
        input  rf_readout1, rf_readout2,
        output busy
    );

    modport master (
        output r0_valid, r0_we, r0_addr1, r0_addr2, r0_wdata,
        output r1_valid, r1_we, r1_addr1, r1_addr2, r1_wdata,
        input  r0_ready, r1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data1, rsp_data2,
        input  rf_read1, rf_read2, rf_write, rf_data, rf_readEnable, rf_writeEnable,
        output rf_readout1, rf_readout2,
        input  busy
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a register file with one-cycle registered reads.
// One transaction at a time: reads take 3 cycles from acceptance, writes take 2.
module regfile_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input logic             clk,
    input logic             reset,
    regfile_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP,
        WR_ISSUE,
        WR_RESP
    } state_t;

    state_t            state;
    logic              ptr;
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr1;
    logic [ADDR_W-1:0] lat_addr2;
    logic [DATA_W-1:0] lat_wdata;

    logic              grant0;
    logic              grant1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr1;
    logic [ADDR_W-1:0] sel_addr2;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_active;
    logic              wr_active;

    // Grants only in IDLE and never during reset; the pointer breaks ties when both ask.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && state == IDLE) begin
            if (bus.r0_valid && (!bus.r1_valid || !ptr))
                grant0 = 1'b1;
            else if (bus.r1_valid)
                grant1 = 1'b1;
        end
        sel_we    = grant1 ? bus.r1_we    : bus.r0_we;
        sel_addr1 = grant1 ? bus.r1_addr1 : bus.r0_addr1;
        sel_addr2 = grant1 ? bus.r1_addr2 : bus.r0_addr2;
        sel_wdata = grant1 ? bus.r1_wdata : bus.r0_wdata;
    end

    assign bus.r0_ready = grant0;
    assign bus.r1_ready = grant1;

    assign rd_active = (state == RD_ISSUE) && !lat_we;
    assign wr_active = (state == WR_ISSUE) &&  lat_we;

    // Register-file strobes decode straight from state and latched fields, so they are zero outside issue cycles.
    assign bus.rf_readEnable  = rd_active;
    assign bus.rf_read1       = rd_active ? lat_addr1 : '0;
    assign bus.rf_read2       = rd_active ? lat_addr2 : '0;
    assign bus.rf_writeEnable = wr_active;
    assign bus.rf_write       = wr_active ? lat_addr1 : '0;
    assign bus.rf_data        = wr_active ? lat_wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            lat_id         <= 1'b0;
            lat_we         <= 1'b0;
            lat_addr1      <= '0;
            lat_addr2      <= '0;
            lat_wdata      <= '0;
            bus.rsp_data1  <= '0;
            bus.rsp_data2  <= '0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        lat_id    <= grant1;
                        lat_we    <= sel_we;
                        lat_addr1 <= sel_addr1;
                        lat_addr2 <= sel_addr2;
                        lat_wdata <= sel_wdata;
                        ptr       <= grant0;
                        state     <= sel_we ? WR_ISSUE : RD_ISSUE;
                        bus.busy  <= 1'b1;
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    bus.rsp_data1  <= bus.rf_readout1;
                    bus.rsp_data2  <= bus.rf_readout2;
                    bus.rsp0_valid <= !lat_id;
                    bus.rsp1_valid <=  lat_id;
                    state          <= RD_RESP;
                end
                RD_RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                WR_ISSUE: begin
                    bus.rsp0_valid <= !lat_id;
                    bus.rsp1_valid <=  lat_id;
                    state          <= WR_RESP;
                end
                WR_RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file preloaded to reg[n] = n+1.
module tb_regfile_arbiter;
   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   pend0;
   int   pend1;
   int   accTotal;
   int   rspTotal;
   logic acc0;
   logic acc1;
   logic [15:0] mem [16];

   regfile_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

   regfile_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file with one-cycle registered read data, preloaded on reset.
   always @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < 16; n++) mem[n] <= 16'(n + 1);
         bus.rf_readout1 <= '0;
         bus.rf_readout2 <= '0;
      end else begin
         if (bus.rf_writeEnable) mem[bus.rf_write] <= bus.rf_data;
         if (bus.rf_readEnable) begin
            bus.rf_readout1 <= mem[bus.rf_read1];
            bus.rf_readout2 <= mem[bus.rf_read2];
         end
      end
   end

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one requester's request fields.
   task automatic applyStimulus(input logic id, input logic v, input logic we,
                                input logic [3:0] a1, input logic [3:0] a2, input logic [15:0] wd);
      if (id == 1'b0) begin
         bus.r0_valid = v; bus.r0_we = we; bus.r0_addr1 = a1; bus.r0_addr2 = a2; bus.r0_wdata = wd;
      end else begin
         bus.r1_valid = v; bus.r1_we = we; bus.r1_addr1 = a1; bus.r1_addr2 = a2; bus.r1_wdata = wd;
      end
   endtask

   // Compare an observed value to the expected one and count failures.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Directed scenarios followed by random traffic.
   initial begin
      checks = 0; failures = 0; pend0 = 0; pend1 = 0; accTotal = 0; rspTotal = 0;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0);
      step();
      bus.r0_valid = 1'b1;
      step();
      checkOutput("rst_r0_ready", bus.r0_ready, 1'b0);
      checkOutput("rst_busy", bus.busy, 1'b0);
      checkOutput("rst_rsp0", bus.rsp0_valid, 1'b0);
      checkOutput("rst_rd_en", bus.rf_readEnable, 1'b0);
      checkOutput("rst_wr_en", bus.rf_writeEnable, 1'b0);
      checkOutput("rst_rsp_data1", bus.rsp_data1, 16'h0000);
      checkOutput("rst_rf_write", bus.rf_write, 4'd0);
      reset = 1'b0;
      bus.r0_valid = 1'b0;
      step();

      $display("[TB] read r0 addr 3/5");
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 4'd5, 16'h0);
      #1;
      checkOutput("rd0_r0_ready", bus.r0_ready, 1'b1);
      checkOutput("rd0_r1_ready", bus.r1_ready, 1'b0);
      step();
      bus.r0_valid = 1'b0;
      checkOutput("rd0_issue_en", bus.rf_readEnable, 1'b1);
      checkOutput("rd0_issue_a1", bus.rf_read1, 4'd3);
      checkOutput("rd0_issue_a2", bus.rf_read2, 4'd5);
      checkOutput("rd0_issue_wen", bus.rf_writeEnable, 1'b0);
      checkOutput("rd0_issue_busy", bus.busy, 1'b1);
      checkOutput("rd0_issue_ready", bus.r0_ready, 1'b0);
      step();
      checkOutput("rd0_wait_en", bus.rf_readEnable, 1'b0);
      checkOutput("rd0_wait_a1", bus.rf_read1, 4'd0);
      checkOutput("rd0_wait_rsp", bus.rsp0_valid, 1'b0);
      step();
      checkOutput("rd0_resp_valid", bus.rsp0_valid, 1'b1);
      checkOutput("rd0_resp_other", bus.rsp1_valid, 1'b0);
      checkOutput("rd0_resp_d1", bus.rsp_data1, 16'h0004);
      checkOutput("rd0_resp_d2", bus.rsp_data2, 16'h0006);
      step();
      checkOutput("rd0_idle_valid", bus.rsp0_valid, 1'b0);
      checkOutput("rd0_idle_busy", bus.busy, 1'b0);

      $display("[TB] write r1 addr 2 then read back");
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd2, 4'd7, 16'hABCD);
      #1;
      checkOutput("wr1_r1_ready", bus.r1_ready, 1'b1);
      step();
      bus.r1_valid = 1'b0;
      checkOutput("wr1_issue_wen", bus.rf_writeEnable, 1'b1);
      checkOutput("wr1_issue_addr", bus.rf_write, 4'd2);
      checkOutput("wr1_issue_data", bus.rf_data, 16'hABCD);
      checkOutput("wr1_issue_ren", bus.rf_readEnable, 1'b0);
      step();
      checkOutput("wr1_resp_valid", bus.rsp1_valid, 1'b1);
      checkOutput("wr1_resp_wen", bus.rf_writeEnable, 1'b0);
      checkOutput("wr1_resp_data", bus.rf_data, 16'h0000);
      checkOutput("wr1_rsp_data_kept", bus.rsp_data1, 16'h0004);
      step();
      checkOutput("wr1_idle_busy", bus.busy, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 16'h0);
      #1;
      checkOutput("rb1_ready", bus.r1_ready, 1'b1);
      step();
      bus.r1_valid = 1'b0;
      step();
      step();
      checkOutput("rb1_resp_valid", bus.rsp1_valid, 1'b1);
      checkOutput("rb1_resp_d1", bus.rsp_data1, 16'hABCD);
      checkOutput("rb1_resp_d2", bus.rsp_data2, 16'h0001);
      step();

      $display("[TB] contention after reset");
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 4'(k), 4'd0, 16'h0);
         applyStimulus(1'b1, 1'b1, 1'b0, 4'(k + 8), 4'd0, 16'h0);
         #1;
         checkOutput("cont_r0_ready", bus.r0_ready, (k % 2 == 0));
         checkOutput("cont_r1_ready", bus.r1_ready, (k % 2 == 1));
         step();
         checkOutput("cont_busy_ready", bus.r0_ready | bus.r1_ready, 1'b0);
         step();
         step();
         checkOutput("cont_rsp0", bus.rsp0_valid, (k % 2 == 0));
         checkOutput("cont_rsp1", bus.rsp1_valid, (k % 2 == 1));
         checkOutput("cont_d1", bus.rsp_data1, (k % 2 == 0) ? 16'(k + 1) : 16'(k + 9));
         step();
      end

      $display("[TB] single requester r1");
      bus.r0_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 4'(k + 4), 4'd15, 16'h0);
         #1;
         checkOutput("single_r1_ready", bus.r1_ready, 1'b1);
         checkOutput("single_r0_ready", bus.r0_ready, 1'b0);
         step();
         step();
         step();
         checkOutput("single_rsp1", bus.rsp1_valid, 1'b1);
         checkOutput("single_d1", bus.rsp_data1, 16'(k + 5));
         checkOutput("single_d2", bus.rsp_data2, 16'h0010);
         step();
      end

      $display("[TB] reset during RD_WAIT");
      bus.r1_valid = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 16'h0);
      #1;
      checkOutput("abort_accept", bus.r0_ready, 1'b1);
      step();
      bus.r0_valid = 1'b0;
      step();
      checkOutput("abort_busy_before", bus.busy, 1'b1);
      reset = 1'b1;
      bus.r1_valid = 1'b1;
      #1;
      checkOutput("abort_ready_in_reset", bus.r1_ready, 1'b0);
      step();
      checkOutput("abort_busy", bus.busy, 1'b0);
      checkOutput("abort_ren", bus.rf_readEnable, 1'b0);
      checkOutput("abort_wen", bus.rf_writeEnable, 1'b0);
      checkOutput("abort_rsp0", bus.rsp0_valid, 1'b0);
      reset = 1'b0;
      bus.r1_valid = 1'b0;
      step();
      checkOutput("abort_no_rsp_a", bus.rsp0_valid, 1'b0);
      step();
      checkOutput("abort_no_rsp_b", bus.rsp0_valid, 1'b0);
      bus.r0_valid = 1'b1;
      bus.r1_valid = 1'b1;
      #1;
      checkOutput("abort_ptr_r0", bus.r0_ready, 1'b1);
      checkOutput("abort_ptr_r1", bus.r1_ready, 1'b0);
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
      step();

      $display("[TB] random traffic");
      for (int c = 0; c < 10000; c++) begin
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 16'($urandom));
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 16'($urandom));
         #1;
         acc0 = bus.r0_valid & bus.r0_ready;
         acc1 = bus.r1_valid & bus.r1_ready;
         checkOutput("rand_one_ready", bus.r0_ready & bus.r1_ready, 1'b0);
         step();
         pend0 += int'(acc0);
         pend1 += int'(acc1);
         accTotal += int'(acc0) + int'(acc1);
         checkOutput("rand_enable_excl", bus.rf_readEnable & bus.rf_writeEnable, 1'b0);
         if (bus.rsp0_valid) begin
            checkOutput("rand_rsp0_pending", (pend0 > 0), 1'b1);
            pend0--;
            rspTotal++;
         end
         if (bus.rsp1_valid) begin
            checkOutput("rand_rsp1_pending", (pend1 > 0), 1'b1);
            pend1--;
            rspTotal++;
         end
      end
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (bus.rsp0_valid) begin
            pend0--;
            rspTotal++;
         end
         if (bus.rsp1_valid) begin
            pend1--;
            rspTotal++;
         end
      end
      checkOutput("rand_pend0_drained", pend0, 0);
      checkOutput("rand_pend1_drained", pend1, 0);
      checkOutput("rand_rsp_count", rspTotal, accTotal);
      checkOutput("rand_traffic_seen", (accTotal > 100), 1'b1);

      $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
